// File: rtl/pipe_latch_skid.sv
// pipe_latch_skid: valid/ready pipeline boundary register with one-entry skid buffer and synchronous flush
// Ports: CLK, nRST (async active-low); in_valid/in_ready/in_data upstream; out_valid/out_ready/out_data
// downstream; flush squashes held entries; occupancy = held entries (0..2).
// Optional PIPE_LATCH_STATS_EN adds saturating stall_cnt[31:0] and flush_cnt[15:0].
module pipe_latch_skid #(
  parameter int DATA_W = 96,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_LATCH_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b11;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_fire, out_fire;
  logic [1:0]        state;
  assign state     = {skid_valid, main_valid};
  assign in_ready  = !skid_valid;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= NOP_VALUE;
      skid_data  <= NOP_VALUE;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= NOP_VALUE;
      skid_data  <= NOP_VALUE;
    end else
      case (state)
        EMPTY: if (in_fire) begin
          main_valid <= 1'b1;
          main_data  <= in_data;
        end
        ONE:
          if (in_fire && out_fire) main_data <= in_data;
          else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
          end else if (out_fire) main_valid <= 1'b0;
        // the skid entry is older than anything upstream, so it moves to main first
        FULL: if (out_fire) begin
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end
        default: begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
`ifdef PIPE_LATCH_STATS_EN
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
      if (flush && occupancy != 2'd0 && !(&flush_cnt)) flush_cnt <= flush_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pipe_latch_skid.sv
// tb_pipe_latch_skid: directed self-checking bench for pipe_latch_skid
module tb_pipe_latch_skid;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [95:0] in_data, out_data;
  logic [1:0]  occupancy;
  int          checks = 0;
  int          errors = 0;
  localparam logic [95:0] A = 96'hAAAA_0000_0001;
  localparam logic [95:0] B = 96'hBBBB_0000_0002;
  localparam logic [95:0] C = 96'hCCCC_0000_0003;
  localparam logic [95:0] D = 96'hDDDD_0000_0004;
  localparam logic [95:0] P = 96'h1234_0040_0044;
`ifdef PIPE_LATCH_STATS_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif
  pipe_latch_skid dut (
    .CLK(clk), .nRST(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_LATCH_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (rst_n) assert (!(dut.skid_valid && !dut.main_valid)) else $error("illegal state 10");
  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic status(input string tag, input logic ov, input logic [95:0] od, input logic [1:0] occ, input logic ir);
    check({tag, "_out_valid"}, 96'(ov === out_valid ? ov : out_valid), 96'(ov));
    check({tag, "_out_data"}, out_data, od);
    check({tag, "_occupancy"}, 96'(occupancy), 96'(occ));
    check({tag, "_in_ready"}, 96'(in_ready), 96'(ir));
  endtask
  task automatic fill_ab();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = A;
    step();
    in_data = B;
    step();
    in_valid = 1'b0;
    status("fill", 1'b1, A, 2'd2, 1'b0);
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    #12;
    status("reset", 1'b0, '0, 2'd0, 1'b1);
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_data = P; out_ready = 1'b1;
    step();
    status("first", 1'b1, P, 2'd1, 1'b1);
    in_valid = 1'b0;
    step();
    status("drain_hold", 1'b0, P, 2'd0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 96'(i);
      step();
      check($sformatf("stream%0d_data", i), out_data, 96'(i));
      check($sformatf("stream%0d_occ", i), 96'(occupancy), 96'd1);
      check($sformatf("stream%0d_valid", i), 96'(out_valid), 96'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_end_valid", 96'(out_valid), 96'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = A;
    step();
    status("bp_a", 1'b1, A, 2'd1, 1'b1);
    in_data = B;
    step();
    status("bp_b", 1'b1, A, 2'd2, 1'b0);
    in_data = C;
    step();
    status("bp_c_held", 1'b1, A, 2'd2, 1'b0);
    out_ready = 1'b1;
    step();
    status("bp_out_b", 1'b1, B, 2'd1, 1'b1);
    step();
    status("bp_out_c", 1'b1, C, 2'd1, 1'b1);
    in_valid = 1'b0;
    step();
    status("bp_empty", 1'b0, C, 2'd0, 1'b1);
    fill_ab();
    in_valid = 1'b1; in_data = D; flush = 1'b1;
    step();
    status("flush", 1'b0, '0, 2'd0, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("no_d%0d", i), 96'(out_valid), 96'd0);
    end
    fill_ab();
    #2 rst_n = 1'b0;
    #1;
    status("async_rst", 1'b0, '0, 2'd0, 1'b1);
    #1 rst_n = 1'b1;
`ifdef PIPE_LATCH_STATS_EN
    check("stats_rst_stall", 96'(stall_cnt), 96'd0);
    check("stats_rst_flush", 96'(flush_cnt), 96'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = A;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    check("stall_cnt", 96'(stall_cnt), 96'd5);
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_cnt", 96'(flush_cnt), 96'd2);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_latch_skid.md
Name: pipe_latch_skid

Overview:
- Parametrised pipeline boundary register. It is the successor to the fixed IF/ID latch.
- Carries an arbitrary-width stage payload (instr, pc, pcplusfour, etc. packed) across a stage boundary.
- Uses a valid/ready handshake instead of bare ihit/dhit enables.
- A one-entry skid buffer gives full throughput with a registered in_ready. A synchronous flush turns the stage into a bubble.

Parameters:
- DATA_W, 96, payload width in bits; must be >= 1.
- NOP_VALUE, '0 (DATA_W bits), value loaded into the payload registers on reset or flush.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents a valid payload.
- in_ready  output  1  latch can accept; registered, equals !skid_valid.
- in_data  input  DATA_W  upstream payload.
- flush  input  1  synchronous squash of all held entries.
- out_valid  output  1  main entry holds a valid payload.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  main-entry payload; driven directly from the register.
- occupancy  output  2  number of held entries, 0..2.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (main_data, main_valid) drives out_*; skid register (skid_data, skid_valid).
- Reset (nRST=0, asynchronous):
  - main_valid=0, skid_valid=0.
  - main_data and skid_data = NOP_VALUE.
  - Outputs: out_valid=0, out_data=NOP_VALUE, in_ready=1, occupancy=0.
- States are encoded by {skid_valid, main_valid}: EMPTY=00, ONE=01, FULL=11. The value 10 is illegal and must never occur; the bench asserts this.
- EMPTY:
  - in_fire -> ONE, main_data<=in_data.
  - Otherwise hold.
- ONE:
  - in_fire & out_fire -> ONE, main_data<=in_data.
  - in_fire & !out_fire -> FULL, skid_data<=in_data.
  - !in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- FULL (in_ready=0, so no in_fire is possible):
  - out_fire -> ONE, main_data<=skid_data, skid_valid<=0.
  - Otherwise hold.
- Flush (highest priority, synchronous):
  - Next state is EMPTY, and main_data and skid_data <= NOP_VALUE.
  - An in_fire in the same cycle is discarded; in_ready is registered and may be 1 that cycle.
  - An out_fire in the same cycle counts as consumed: downstream already sampled out_data.
- Latency and throughput:
  - Payload accepted on edge N is visible on out_data after edge N; 1-cycle latency.
  - With out_ready held high, sustained throughput is 1 payload per cycle.
- Ordering: strict FIFO order; the skid entry is always older than any new input.
- Hold rule: after out_fire drains to EMPTY, out_data keeps its last value. Downstream must qualify with out_valid.
- occupancy = main_valid + skid_valid.
- No combinational path from out_ready to in_ready; in_ready is registered.
- Reset asserted mid-transfer clears all state immediately, independent of CLK.

Optional Feature:
- Macro PIPE_LATCH_STATS_EN.
- When defined, the block adds output stall_cnt[31:0] and output flush_cnt[15:0].
  - stall_cnt increments each cycle where out_valid & !out_ready.
  - flush_cnt increments on each cycle where flush=1 and occupancy != 0.
  - Both counters saturate at all-ones and reset to 0 on nRST=0.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then in_valid=1 with in_data=0x...1234_0040_0044 and out_ready=1 -> one cycle later out_valid=1, out_data=that value, occupancy=1, in_ready=1.
- Streaming: out_ready=1, in_valid=1 for payloads 1..8 on consecutive cycles -> out_data=1..8 on consecutive cycles, no bubbles, occupancy stays 1.
- Back-pressure: hold out_ready=0 and send A, B, C back-to-back:
  - A and B are accepted, occupancy=2, in_ready=0 after B, and C is held upstream.
  - Raise out_ready -> outputs A, B, C in order with no loss or duplication.
- Flush while FULL (A in main, B in skid), with in_valid=1 carrying D in the same cycle:
  - Next cycle out_valid=0, occupancy=0, out_data=NOP_VALUE, in_ready=1.
  - D is never output.
- Asynchronous reset mid-stream, nRST low between clock edges while occupancy=2 -> out_valid=0, in_ready=1, occupancy=0 immediately, before the next edge.
- With PIPE_LATCH_STATS_EN defined:
  - 5 cycles of out_valid=1 with out_ready=0 -> stall_cnt=5.
  - Two flushes with occupancy>0 and one with occupancy=0 -> flush_cnt=2.
